// File: rtl/uart_rx.sv
// 8N1 UART receiver that assembles WORD_BYTES bytes, first byte in the low bits, into one output word.
// It uses a valid/ready output and reports a bad stop bit and a dropped word with one-cycle pulses.
module uart_rx #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] prescaler,
  input  logic        rx,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  localparam int unsigned LAST_BYTE = WORD_BYTES - 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [31:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic [31:0] mid;
  logic        baud_hit;

  assign mid      = prescaler >> 1;
  assign baud_hit = (baud_q == prescaler);

  // State and datapath registers, with the two synchronizer flops
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // Next-state logic. A zero mid-bit offset means the detecting cycle is itself the start sample.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rx_s_q) state_d = (mid == 32'd0) ? DATA : START;
      START: if (baud_q == mid) state_d = rx_s_q ? IDLE : DATA;
      DATA:  if (baud_hit && bit_idx_q == 3'd7) state_d = STOP;
      STOP:  if (baud_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    baud_d     = baud_q + 32'd1;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    word_d     = word_q;
    data_d     = data_q;
    valid_d    = valid_q && !ready_i;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
      end
      START: begin
        if (baud_q == mid) begin
          baud_d    = '0;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (baud_hit) begin
          baud_d    = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_hit) begin
          baud_d = '0;
          if (rx_s_q) begin
            word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'(LAST_BYTE)) begin
              if (valid_q && !ready_i) begin
                ovr_d = 1'b1;
              end else begin
                data_d  = word_d;
                valid_d = 1'b1;
              end
            end
          end else begin
            ferr_d     = 1'b1;
            byte_idx_d = '0;
            word_d     = '0;
          end
        end
      end
      default: baud_d = '0;
    endcase
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serializes 8N1 frames and checks the received words and the status pulses.
// Expected values are hand-computed constants.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] prescaler;
  logic        rx;
  logic        ready_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        frame_err_o;
  logic        overrun_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] words[$];
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int base_w, base_f, base_o;

  uart_rx #(.WORD_BYTES(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .prescaler(prescaler), .rx(rx),
    .ready_i(ready_i), .data_o(data_o), .valid_o(valid_o),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Collects consumed words and counts status pulses, once per cycle
  always @(negedge clk) begin
    if (!reset_i) begin
      if (valid_o && ready_i) words.push_back(data_o);
      if (frame_err_o) ferr_cnt++;
      if (overrun_o) ovr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (int'(prescaler) + 1) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_v);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic mark();
    base_w = words.size();
    base_f = ferr_cnt;
    base_o = ovr_cnt;
  endtask

  initial begin
    reset_i   = 1'b1;
    prescaler = 32'd3;
    rx        = 1'b1;
    ready_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data_o, 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_ferr", 32'(frame_err_o), 32'h0);
    chk("rst_ovr", 32'(overrun_o), 32'h0);
    reset_i = 1'b0;
    idle_bits(2);

    // One word at 4 cycles per bit
    mark();
    send_word(32'h12345678);
    idle_bits(4);
    chk("p3_count", 32'(words.size() - base_w), 32'd1);
    chk("p3_word", words[base_w], 32'h12345678);
    chk("p3_ferr", 32'(ferr_cnt - base_f), 32'd0);
    chk("p3_ovr", 32'(ovr_cnt - base_o), 32'd0);

    // Back-to-back words at one cycle per bit
    prescaler = 32'd0;
    idle_bits(4);
    mark();
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    idle_bits(12);
    chk("p0_count", 32'(words.size() - base_w), 32'd2);
    chk("p0_word0", words[base_w], 32'h12345678);
    chk("p0_word1", words[base_w + 1], 32'hDEADBEEF);
    chk("p0_ferr", 32'(ferr_cnt - base_f), 32'd0);

    // Short low glitch must be rejected at the start sample
    prescaler = 32'd7;
    idle_bits(2);
    mark();
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_bits(6);
    chk("glitch_words", 32'(words.size() - base_w), 32'd0);
    chk("glitch_ferr", 32'(ferr_cnt - base_f), 32'd0);
    chk("glitch_ovr", 32'(ovr_cnt - base_o), 32'd0);
    chk("glitch_valid", 32'(valid_o), 32'h0);

    // Bad stop bit, then a clean word
    prescaler = 32'd3;
    idle_bits(2);
    mark();
    send_byte(8'hA5, 1'b0);
    idle_bits(4);
    chk("ferr_pulse", 32'(ferr_cnt - base_f), 32'd1);
    chk("ferr_words", 32'(words.size() - base_w), 32'd0);
    send_word(32'h04030201);
    idle_bits(4);
    chk("ferr_after_count", 32'(words.size() - base_w), 32'd1);
    chk("ferr_after_word", words[base_w], 32'h04030201);

    // Overrun while the consumer stalls
    ready_i = 1'b0;
    mark();
    send_word(32'h11111111);
    idle_bits(2);
    chk("stall_valid", 32'(valid_o), 32'h1);
    chk("stall_data", data_o, 32'h11111111);
    send_word(32'h22222222);
    idle_bits(4);
    chk("ovr_pulse", 32'(ovr_cnt - base_o), 32'd1);
    chk("ovr_data", data_o, 32'h11111111);
    chk("ovr_valid", 32'(valid_o), 32'h1);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_clears", 32'(valid_o), 32'h0);
    chk("ready_word", words[base_w], 32'h11111111);
    idle_bits(2);

    // Reset mid-word drops the partial bytes
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_data", data_o, 32'h0);
    chk("midrst_valid", 32'(valid_o), 32'h0);
    rx = 1'b1;
    reset_i = 1'b0;
    idle_bits(2);
    mark();
    send_word(32'hCAFEF00D);
    idle_bits(4);
    chk("midrst_count", 32'(words.size() - base_w), 32'd1);
    chk("midrst_word", words[base_w], 32'hCAFEF00D);
    chk("midrst_ferr", 32'(ferr_cnt - base_f), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter WORD_BYTES, default 4, SHALL set the number of received bytes assembled into one output word; only the value 4 is required.
REQ-002 clk_i  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset_i  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 prescaler  input  32  bit period in clk_i cycles = prescaler+1; SHALL be held stable while a frame is in progress.
REQ-005 rx  input  1  serial line, idle high; the line driven by the uart transmitter's tx.
REQ-006 data_o  output  32  assembled word; first received byte in bits [7:0], fourth in [31:24].
REQ-007 valid_o  output  1  data_o holds an unconsumed word.
REQ-008 ready_i  input  1  consumer accepts data_o in any cycle where valid_o && ready_i.
REQ-009 frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-010 overrun_o  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s); all sampling uses rx_s, giving 2 cycles of input latency.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; a 32-bit baud counter, 3-bit bit index, 2-bit byte index and 8-bit shift register.
REQ-013 IDLE: when rx_s==0, go to START with baud counter = 0.
REQ-014 START: sample at baud counter == prescaler>>1; rx_s==1 (glitch) -> IDLE with no output; rx_s==0 -> DATA with counter reset and bit index 0.
REQ-015 DATA: sample every prescaler+1 cycles after the start sample; shift rx_s in LSB first; after bit index 7 -> STOP.
REQ-016 STOP: sample prescaler+1 cycles after bit 7; rx_s==1 stores the byte at the byte index and increments the index (wraps 3->0); rx_s==0 pulses frame_err_o, discards the byte and the partial word, and clears the byte index.
REQ-017 From STOP, return to IDLE on the same edge as the stop sample; a new start bit SHALL be detected from the next cycle.
REQ-018 Word completion is the stop sample of byte 3 with byte index 3; on the next edge data_o SHALL load the assembled word and valid_o SHALL go 1.
REQ-019 valid_o SHALL stay high, with data_o stable, until a cycle with ready_i==1; it then clears on the next edge unless REQ-020 applies.
REQ-020 Completion in a cycle where valid_o && ready_i: the old word is consumed, the new word loads, and valid_o stays 1; no overrun.
REQ-021 Completion while valid_o && !ready_i: the new word is dropped, data_o is unchanged, and overrun_o pulses for 1 cycle.
REQ-022 prescaler==0 SHALL be supported: one sample per cycle with the start sample at counter 0.
REQ-023 The receiver SHALL never stall the line; reception continues regardless of valid_o.

Reset
REQ-024 While reset_i==1: FSM=IDLE; counters, byte index and shift register = 0; synchronizer flops = 1; data_o=0; valid_o=0; frame_err_o=0; overrun_o=0.
REQ-025 Reset asserted mid-frame or mid-word SHALL abandon all partial data; after release, the first falling edge on rx_s starts a new word at byte 0.

Verification
REQ-026 prescaler=3, ready_i=1, serialize bytes 0x78,0x56,0x34,0x12 (8N1, 4 cycles/bit) -> one valid_o pulse with data_o=0x12345678, and no error pulses.
REQ-027 prescaler=0, back-to-back words 0x12345678 then 0xDEADBEEF, ready_i=1 -> two valid words in order, each matching the sent value.
REQ-028 prescaler=7, rx low for 2 cycles then high -> no state beyond START, and valid_o, frame_err_o and overrun_o stay 0.
REQ-029 prescaler=3, byte 0xA5 with stop bit driven 0 -> frame_err_o pulses once; then bytes 0x01,0x02,0x03,0x04 -> data_o=0x04030201.
REQ-030 ready_i=0, send 0x11111111 then 0x22222222 -> data_o stays 0x11111111 and overrun_o pulses once; raising ready_i clears valid_o next cycle.
REQ-031 Reset asserted after 2 bytes of a word, then 4 fresh bytes 0xCAFEF00D (LSB first) -> data_o=0xCAFEF00D, with no stale bytes.
